// File: rtl/frame_txd.sv
// Framed serial transmitter: 0x55, 0xAA, length, payload as UART-style bytes on one line.
// Optional FRAME_TXD_CHECKSUM_EN appends an XOR checksum of length and payload.
module frame_txd #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HDR0         = 8'h55,
    parameter logic [7:0]  HDR1         = 8'hAA
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       stream,
    output logic       busy,
    output logic       done
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LEN,
        S_PAY,
`ifdef FRAME_TXD_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  rem_q, rem_d;
    logic [9:0]  sr_q, sr_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [15:0] timer_q, timer_d;
    logic        active_q, active_d;
`ifdef FRAME_TXD_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic       bit_end;
    logic       byte_end;
    logic       ser_empty;
    logic       load;
    logic [7:0] load_byte;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        sr_d       = sr_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = timer_q;
        active_d   = active_q;
`ifdef FRAME_TXD_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        load       = 1'b0;
        load_byte  = 8'h00;

        bit_end    = active_q && (timer_q == BIT_LAST);
        byte_end   = bit_end && (bit_idx_q == 4'd9);
        // "Empty" includes the last stop-bit cycle so the next byte can follow with no gap.
        ser_empty  = !active_q || byte_end;
        data_ready = (state_q == S_PAY) && ser_empty && (rem_q != 8'd0);

        if (active_q) begin
            if (bit_end) begin
                timer_d = 16'd0;
                sr_d    = {1'b1, sr_q[9:1]};
                if (bit_idx_q == 4'd9) begin
                    active_d = 1'b0;
                end else begin
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = len;
                    rem_d     = len;
`ifdef FRAME_TXD_CHECKSUM_EN
                    csum_d    = len;
`endif
                    load      = 1'b1;
                    load_byte = HDR0;
                    state_d   = S_HDR0;
                end
            end
            S_HDR0: begin
                if (byte_end) begin
                    load      = 1'b1;
                    load_byte = HDR1;
                    state_d   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (byte_end) begin
                    load      = 1'b1;
                    load_byte = len_q;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                // Enter PAY as the length byte's stop bit begins, so the handshake
                // window already covers that byte's final cycle.
                if (len_q != 8'd0) begin
                    if (bit_end && (bit_idx_q == 4'd8)) begin
                        state_d = S_PAY;
                    end
                end else if (byte_end) begin
`ifdef FRAME_TXD_CHECKSUM_EN
                    load      = 1'b1;
                    load_byte = csum_q;
                    state_d   = S_CSUM;
`else
                    state_d   = S_FIN;
`endif
                end
            end
            S_PAY: begin
                if (rem_q != 8'd0) begin
                    if (data_ready && data_valid) begin
                        load      = 1'b1;
                        load_byte = data_in;
                        rem_d     = rem_q - 8'd1;
`ifdef FRAME_TXD_CHECKSUM_EN
                        csum_d    = csum_q ^ data_in;
`endif
                    end
                end else if (ser_empty) begin
`ifdef FRAME_TXD_CHECKSUM_EN
                    load      = 1'b1;
                    load_byte = csum_q;
                    state_d   = S_CSUM;
`else
                    state_d   = S_FIN;
`endif
                end
            end
`ifdef FRAME_TXD_CHECKSUM_EN
            S_CSUM: begin
                if (byte_end) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load) begin
            sr_d      = {1'b1, load_byte, 1'b0};
            bit_idx_d = 4'd0;
            timer_d   = 16'd0;
            active_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= 8'd0;
            rem_q     <= 8'd0;
            sr_q      <= '1;
            bit_idx_q <= 4'd0;
            timer_q   <= 16'd0;
            active_q  <= 1'b0;
`ifdef FRAME_TXD_CHECKSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            sr_q      <= sr_d;
            bit_idx_q <= bit_idx_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
`ifdef FRAME_TXD_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign stream = sr_q[0];
    assign busy   = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done   = (state_q == S_FIN);

endmodule
